// File: rtl/mips_muldiv_pkg.sv
// Shared types and helpers for the iterative HI/LO multiply/divide unit.
package mips_muldiv_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } muldiv_state_t;

  localparam int MULDIV_DEFAULT_WIDTH = 32;
  localparam int MULDIV_CNT_W         = $clog2(MULDIV_DEFAULT_WIDTH);

  // Iteration counter width for a given operand width.
  function automatic int cntWidth(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/mips_muldiv_step.sv
// One combinational iteration of the shift-add multiplier or the restoring divider.
// Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
// Divide:   acc = {remainder, quotient}, shifted left; the new quotient bit is
//           returned separately and left as zero in acc_o.
module mips_muldiv_step
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_DEFAULT_WIDTH
) (
  input  logic               divMode_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   operand_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic               qbit_o
);

  logic [WIDTH:0] mulSum;
  logic [WIDTH:0] remShift;
  logic [WIDTH:0] trialDiff;

  // Compute either the add-and-shift-right or the shift-left-and-trial-subtract step.
  always_comb begin
    mulSum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand_i} : '0);
    remShift  = acc_i[2*WIDTH-1:WIDTH-1];
    trialDiff = remShift - {1'b0, operand_i};
    acc_o     = '0;
    qbit_o    = 1'b0;
    if (divMode_i) begin
      if (!trialDiff[WIDTH]) begin
        acc_o  = {trialDiff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
        qbit_o = 1'b1;
      end else begin
        acc_o  = {remShift[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = {mulSum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO; one bit per cycle with a
// start/busy/done handshake, plus a final signed-correction cycle.
module mips_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = cntWidth(WIDTH);

  muldiv_state_t      state_q, state_d;
  muldiv_op_t         op_q, op_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   operand_q, operand_d;
  logic               negA_q, negA_d;
  logic               negB_q, negB_d;
  logic               div0_q, div0_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  logic               inSigned;
  logic               inDiv;
  logic               inDivZero;
  logic [WIDTH-1:0]   magA, magB;
  logic               fixExit;
  logic               runDiv;
  logic [2*WIDTH-1:0] stepAcc;
  logic               stepQbit;
  logic [2*WIDTH-1:0] prodFixed;
  logic [WIDTH-1:0]   hiRes, loRes;

  // Decode the incoming operation and take operand magnitudes for signed ops.
  always_comb begin
    inSigned  = (op_i == MULT) || (op_i == DIV);
    inDiv     = (op_i == DIV) || (op_i == DIVU);
    inDivZero = inDiv && (opb_i == '0);
    magA      = (inSigned && opa_i[WIDTH-1]) ? -opa_i : opa_i;
    magB      = (inSigned && opb_i[WIDTH-1]) ? -opb_i : opb_i;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; divide-by-zero skips the iterations entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_i) state_d = inDivZero ? FIX : RUN;
      RUN:  if (cnt_q == '0) state_d = FIX;
      FIX:  if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: busy flag and the edge that commits the result.
  always_comb begin
    busy_o  = (state_q != IDLE);
    fixExit = (state_q == FIX) && (cnt_q == '0);
  end

  assign runDiv = (op_q == DIV) || (op_q == DIVU);

  mips_muldiv_step #(
    .WIDTH(WIDTH)
  ) uStep (
    .divMode_i(runDiv),
    .acc_i    (acc_q),
    .operand_i(operand_q),
    .acc_o    (stepAcc),
    .qbit_o   (stepQbit)
  );

  // Datapath next state: operand capture, one iteration per RUN cycle, FIX countdown.
  always_comb begin
    op_d      = op_q;
    acc_d     = acc_q;
    operand_d = operand_q;
    negA_d    = negA_q;
    negB_d    = negB_q;
    div0_d    = div0_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          op_d   = muldiv_op_t'(op_i);
          negA_d = inSigned && opa_i[WIDTH-1];
          negB_d = inSigned && opb_i[WIDTH-1];
          if (inDivZero) begin
            acc_d     = {opa_i, {WIDTH{1'b1}}};
            operand_d = '0;
            div0_d    = 1'b1;
            cnt_d     = CW'(1);
          end else begin
            acc_d     = {{WIDTH{1'b0}}, inDiv ? magA : magB};
            operand_d = inDiv ? magB : magA;
            div0_d    = 1'b0;
            cnt_d     = CW'(WIDTH - 1);
          end
        end
      end
      RUN: begin
        acc_d = stepAcc | {{(2*WIDTH-1){1'b0}}, stepQbit};
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      end
      FIX: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      end
      default: ;
    endcase
  end

  // Datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= MULT;
      acc_q     <= '0;
      operand_q <= '0;
      negA_q    <= 1'b0;
      negB_q    <= 1'b0;
      div0_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      op_q      <= op_d;
      acc_q     <= acc_d;
      operand_q <= operand_d;
      negA_q    <= negA_d;
      negB_q    <= negB_d;
      div0_q    <= div0_d;
      cnt_q     <= cnt_d;
    end
  end

  // Signed correction of the raw magnitude result; divide-by-zero passes through raw.
  always_comb begin
    prodFixed = (negA_q ^ negB_q) ? -acc_q : acc_q;
    hiRes     = prodFixed[2*WIDTH-1:WIDTH];
    loRes     = prodFixed[WIDTH-1:0];
    if (runDiv) begin
      if (div0_q) begin
        hiRes = acc_q[2*WIDTH-1:WIDTH];
        loRes = acc_q[WIDTH-1:0];
      end else begin
        hiRes = negA_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        loRes = (negA_q ^ negB_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      end
    end
  end

  // HI/LO registers and done pulse; an operation result beats a coincident mthi/mtlo.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= fixExit;
      if (fixExit) begin
        hi_q <= hiRes;
        lo_q <= loRes;
      end else begin
        if (mthi_i) hi_q <= opa_i;
        if (mtlo_i) lo_q <= opa_i;
      end
    end
  end

  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: expected HI/LO and latency are queued
// when an operation is launched and compared when done pulses.
module tb_mips_muldiv_unit;

  localparam int W = 32;

  logic          clk;
  logic          reset;
  logic          start_i;
  logic [1:0]    op_i;
  logic [W-1:0]  opa_i;
  logic [W-1:0]  opb_i;
  logic          mthi_i;
  logic          mtlo_i;
  logic          busy_o;
  logic          done_o;
  logic [W-1:0]  hi_o;
  logic [W-1:0]  lo_o;

  int            total;
  int            bad;
  logic [63:0]   expQ[$];
  int            latQ[$];

  mips_muldiv_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start_i(start_i),
    .op_i   (op_i),
    .opa_i  (opa_i),
    .opb_i  (opb_i),
    .mthi_i (mthi_i),
    .mtlo_i (mtlo_i),
    .busy_o (busy_o),
    .done_o (done_o),
    .hi_o   (hi_o),
    .lo_o   (lo_o)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report a mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference model returning {hi, lo}.
  function automatic logic [63:0] modelResult(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, tq, tr;
    logic [31:0]        uq, ur;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (o)
      2'b00: return sa * sb;
      2'b01: return {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        tq = sa / sb;
        tr = sa % sb;
        return {tr[31:0], tq[31:0]};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        uq = a / b;
        ur = a % b;
        return {ur, uq};
      end
    endcase
  endfunction

  // Launch one operation (called at a negedge) and compare on done.
  // disturb: 0 none, 1 ignored starts + mthi mid-run, 2 mthi/mtlo at FIX exit, 3 reset mid-run.
  task automatic applyStimulus(input logic [1:0] opSel, input logic [31:0] a, input logic [31:0] b,
                               input int disturb);
    logic [63:0] exp;
    int          expLat;
    int          lat;
    int          busyCnt;
    int          extraDone;
    bit          seen;
    bit          resetHit;
    exp    = modelResult(opSel, a, b);
    expLat = (opSel[1] && b == 32'h0) ? 2 : W + 1;
    expQ.push_back(exp);
    latQ.push_back(expLat);
    op_i    = opSel;
    opa_i   = a;
    opb_i   = b;
    start_i = 1'b1;
    @(negedge clk);
    start_i  = 1'b0;
    lat      = 0;
    busyCnt  = 0;
    seen     = 1'b0;
    resetHit = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      if (busy_o) busyCnt++;
      start_i = 1'b0;
      mthi_i  = 1'b0;
      mtlo_i  = 1'b0;
      if (disturb == 1) begin
        if (lat == 5 || lat == 20) begin
          start_i = 1'b1;
          op_i    = 2'b11;
          opa_i   = 32'hDEAD0000;
          opb_i   = 32'h3;
        end
        if (lat == 10) begin
          mthi_i = 1'b1;
          opa_i  = 32'h1234;
        end
        if (lat == 11) checkOutput("mthi_mid", {32'b0, hi_o}, 64'h1234);
        if (lat == 31) checkOutput("mthi_hold", {32'b0, hi_o}, 64'h1234);
      end
      if (disturb == 2 && lat == W) begin
        mthi_i = 1'b1;
        mtlo_i = 1'b1;
        opa_i  = 32'h5555AAAA;
      end
      if (disturb == 3 && lat == 10) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rst_busy", {63'b0, busy_o}, 64'h0);
        checkOutput("rst_done", {63'b0, done_o}, 64'h0);
        checkOutput("rst_hilo", {hi_o, lo_o}, 64'h0);
        resetHit = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    start_i = 1'b0;
    mthi_i  = 1'b0;
    mtlo_i  = 1'b0;
    if (resetHit) begin
      void'(expQ.pop_back());
      void'(latQ.pop_back());
      return;
    end
    if (!seen) begin
      checkOutput("timeout", 64'h0, 64'h1);
      void'(expQ.pop_front());
      void'(latQ.pop_front());
      return;
    end
    checkOutput("result", {hi_o, lo_o}, expQ.pop_front());
    checkOutput("latency", 64'(lat), 64'(latQ.pop_front()));
    checkOutput("busycycles", 64'(busyCnt), 64'(expLat));
    if (disturb == 1) begin
      extraDone = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (done_o) extraDone++;
      end
      checkOutput("extra_done", 64'(extraDone), 64'h0);
      checkOutput("held_result", {hi_o, lo_o}, exp);
    end
  endtask

  // Directed cases from the plan, a few random ones, then the hazard scenarios.
  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    total   = 0;
    bad     = 0;
    reset   = 1'b1;
    start_i = 1'b0;
    op_i    = 2'b00;
    opa_i   = '0;
    opb_i   = '0;
    mthi_i  = 1'b0;
    mtlo_i  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", {63'b0, busy_o}, 64'h0);
    checkOutput("reset_done", {63'b0, done_o}, 64'h0);
    checkOutput("reset_hilo", {hi_o, lo_o}, 64'h0);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    checkOutput("multu_max_const", {hi_o, lo_o}, 64'hFFFFFFFE_00000001);
    applyStimulus(2'b00, 32'hFFFFFFFD, 32'h00000007, 0);
    checkOutput("mult_neg_const", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFEB);
    applyStimulus(2'b00, 32'h80000000, 32'h80000000, 0);
    applyStimulus(2'b10, 32'hFFFFFFF9, 32'h00000002, 0);
    checkOutput("div_neg_const", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFD);
    applyStimulus(2'b11, 32'h00000007, 32'h00000002, 0);
    applyStimulus(2'b10, 32'h80000000, 32'hFFFFFFFF, 0);
    checkOutput("div_ovf_const", {hi_o, lo_o}, 64'h00000000_80000000);
    applyStimulus(2'b11, 32'h00000005, 32'h00000000, 0);
    checkOutput("divu_zero_const", {hi_o, lo_o}, 64'h00000005_FFFFFFFF);
    applyStimulus(2'b10, 32'hFFFFFFF0, 32'h00000000, 0);

    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom >> $urandom_range(0, 30);
      applyStimulus(rop, ra, rb, 0);
    end

    applyStimulus(2'b01, 32'h00012345, 32'h00006789, 1);
    applyStimulus(2'b00, 32'h7FFFFFFF, 32'hFFFFFFFE, 2);
    applyStimulus(2'b10, 32'hFFFF0000, 32'h00000013, 3);
    applyStimulus(2'b10, 32'h00000064, 32'hFFFFFFF9, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
